// File: rtl/mem_latency_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_latency_if
//  Purpose  : Request/ready handshake bundle between the control unit and the
//             unified memory. Carries err when MEM_ALIGN_CHECK_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_latency_if #(
  parameter int ADDR_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic              i_or_d;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              busy;
`ifdef MEM_ALIGN_CHECK_EN
  logic              err;

  modport master (
    output mem_read, mem_write, i_or_d, pc, data_addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  mem_read, mem_write, i_or_d, pc, data_addr, wdata,
    output rdata, ready, busy, err
  );
`else
  modport master (
    output mem_read, mem_write, i_or_d, pc, data_addr, wdata,
    input  rdata, ready, busy
  );

  modport slave (
    input  mem_read, mem_write, i_or_d, pc, data_addr, wdata,
    output rdata, ready, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/mem_latency_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_latency_unit
//  Purpose  : Unified instruction/data word memory with a fixed multi-cycle
//             access latency. Optional macro MEM_ALIGN_CHECK_EN adds err.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_latency_unit #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  wire logic    clk,
  input  wire logic    reset,
  mem_latency_if.slave bus
);

  localparam int         c_IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_BUSY = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [3:0]         r_cnt;

  logic               r_is_write;
  logic [31:0]        r_wdata;
  logic [c_IDX_W-1:0] r_index;
  logic [31:0]        r_rdata;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               w_req;
  logic               w_accept;
  logic               w_enter_done;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [c_IDX_W-1:0] w_sel_index;
  logic               w_sel_err;

  logic               w_acc_write;
  logic [c_IDX_W-1:0] w_acc_index;
  logic [31:0]        w_acc_wdata;
  logic               w_acc_err;

  logic               w_ready;
  logic               w_busy;

  assign w_req       = bus.mem_read | bus.mem_write;
  assign w_accept    = (r_state == c_ST_IDLE) && w_req;
  assign w_sel_addr  = bus.i_or_d ? bus.data_addr : bus.pc;
  assign w_sel_index = w_sel_addr[c_IDX_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  logic r_err;

  assign w_sel_err = (w_sel_addr[1:0] != 2'b00) ||
                     ((w_sel_addr >> (c_IDX_W + 2)) != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_sel_err;
    end
  end

  assign bus.err = w_ready & r_err;
`else
  logic w_unused_addr;

  // Offset and upper address bits are deliberately ignored: addresses wrap.
  assign w_unused_addr = ^w_sel_addr;
  assign w_sel_err     = 1'b0;
`endif

  // With LATENCY=1 the array is accessed on the acceptance edge itself, so the
  // freshly selected request must be used instead of the latched copy.
  assign w_acc_write  = w_accept ? bus.mem_write : r_is_write;
  assign w_acc_index  = w_accept ? w_sel_index   : r_index;
  assign w_acc_wdata  = w_accept ? bus.wdata     : r_wdata;
`ifdef MEM_ALIGN_CHECK_EN
  assign w_acc_err    = w_accept ? w_sel_err     : r_err;
`else
  assign w_acc_err    = 1'b0;
`endif
  assign w_enter_done = (r_state != c_ST_DONE) && (w_state_nxt == c_ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = (LATENCY == 1) ? c_ST_DONE : c_ST_BUSY;
        end
      end
      c_ST_BUSY: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = c_ST_DONE;
        end
      end
      c_ST_DONE: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      c_ST_BUSY: w_busy = 1'b1;
      c_ST_DONE: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= c_CNT_LOAD;
    end else if (r_state == c_ST_BUSY) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_write <= 1'b0;
      r_wdata    <= 32'h0;
      r_index    <= '0;
    end else if (w_accept) begin
      r_is_write <= bus.mem_write;
      r_wdata    <= bus.wdata;
      r_index    <= w_sel_index;
    end
  end

  // Array has no reset; a reset mid-transaction drops the pending write.
  always_ff @(posedge clk) begin
    if (!reset && w_enter_done && w_acc_write && !w_acc_err) begin
      r_mem[w_acc_index] <= w_acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 32'h0;
    end else if (w_enter_done && !w_acc_write) begin
      r_rdata <= w_acc_err ? 32'h0 : r_mem[w_acc_index];
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ready = w_ready;
  assign bus.busy  = w_busy;

endmodule
`default_nettype wire
